// File: rtl/mcdt_wrr_arbiter.sv
// rtl/mcdt_wrr_arbiter.sv - weighted round-robin arbiter for the three MCDT slave FIFOs
// Optional per-channel popped-word counters: define MCDT_ARB_WORD_CNT_EN.
module mcdt_wrr_arbiter #(
  parameter int DW = 32,
  parameter int WW = 4,
  parameter int CW = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [DW-1:0]   slv0_data_i,
  input  logic [DW-1:0]   slv1_data_i,
  input  logic [DW-1:0]   slv2_data_i,
  input  logic [2:0]      slv_req_i,
  input  logic [2:0]      ch_en_i,
  input  logic [3*WW-1:0] weight_i,
  output logic [2:0]      a2s_ack_o,
  output logic            data_val_o,
  output logic [1:0]      arb_id_o,
  output logic [DW-1:0]   arb_data_o,
  output logic            busy_o
`ifdef MCDT_ARB_WORD_CNT_EN
  ,
  output logic [3*CW-1:0] word_cnt_o
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cur, cur_nxt;
  logic [1:0]    last, last_nxt;
  logic [WW-1:0] credit, credit_nxt;
  logic [2:0]    elig;
  logic [2:0]    ack;
  logic [1:0]    pick;
  logic [WW-1:0] pick_weight;
  logic [DW-1:0] cur_data;

  // First eligible channel after the previous grant, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] prev, input logic [2:0] req);
    logic [1:0] res;
    logic       found;
    int         idx;
    res   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(prev) + k) % 3;
      if (!found && req[idx]) begin
        res   = 2'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign elig        = slv_req_i & ch_en_i;
  assign pick        = rr_pick(last, elig);
  assign pick_weight = weight_i[int'(pick)*WW +: WW];
  assign a2s_ack_o   = ack;
  assign busy_o      = (state == BURST);

  // Head word of the granted channel, captured into the output register on ack.
  always_comb begin
    case (cur)
      2'd0:    cur_data = slv0_data_i;
      2'd1:    cur_data = slv1_data_i;
      default: cur_data = slv2_data_i;
    endcase
  end

  // Arbiter state, grant pointer and burst credit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      cur    <= 2'd0;
      last   <= 2'd2;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      cur    <= cur_nxt;
      last   <= last_nxt;
      credit <= credit_nxt;
    end
  end

  // Grant selection in IDLE; pop and credit accounting in BURST.
  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    last_nxt   = last;
    credit_nxt = credit;
    ack        = 3'b000;
    case (state)
      IDLE: begin
        if (elig != 3'b000) begin
          cur_nxt    = pick;
          last_nxt   = pick;
          credit_nxt = (pick_weight == '0) ? WW'(1) : pick_weight;
          state_nxt  = BURST;
        end
      end
      BURST: begin
        if (elig[cur] && (credit != '0)) begin
          ack[cur]   = 1'b1;
          credit_nxt = credit - WW'(1);
          if (credit == WW'(1)) begin
            state_nxt = IDLE;
          end
        end else begin
          // Channel dropped out (or credit exhausted): release the output.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output word; id and data hold between words.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_val_o <= 1'b0;
      arb_id_o   <= 2'd0;
      arb_data_o <= '0;
    end else begin
      data_val_o <= (ack != 3'b000);
      if (ack != 3'b000) begin
        arb_id_o   <= cur;
        arb_data_o <= cur_data;
      end
    end
  end

`ifdef MCDT_ARB_WORD_CNT_EN
  // Free-running per-channel popped-word counters, wrapping at 2^CW.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_cnt_o <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (ack[n]) begin
          word_cnt_o[n*CW +: CW] <= word_cnt_o[n*CW +: CW] + CW'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mcdt_wrr_arbiter.sv
// tb/tb_mcdt_wrr_arbiter.sv - self-checking bench for mcdt_wrr_arbiter
module tb_mcdt_wrr_arbiter;
  localparam int DW = 32;
  localparam int WW = 4;
`ifdef MCDT_ARB_WORD_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic [DW-1:0]   d0, d1, d2;
  logic [2:0]      req, en;
  logic [3*WW-1:0] wt;
  logic [2:0]      ack;
  logic            val;
  logic [1:0]      id;
  logic [DW-1:0]   data;
  logic            busy;
`ifdef MCDT_ARB_WORD_CNT_EN
  logic [3*CW-1:0] wcnt;
`endif

  always #5 clk = ~clk;

  mcdt_wrr_arbiter #(.DW(DW), .WW(WW), .CW(CW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .slv0_data_i(d0), .slv1_data_i(d1), .slv2_data_i(d2),
    .slv_req_i(req), .ch_en_i(en), .weight_i(wt),
    .a2s_ack_o(ack), .data_val_o(val), .arb_id_o(id), .arb_data_o(data),
    .busy_o(busy)
`ifdef MCDT_ARB_WORD_CNT_EN
    , .word_cnt_o(wcnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO models feeding the DUT
  logic [DW-1:0] q0[$], q1[$], q2[$];
  int wseq[3];

  function automatic logic [DW-1:0] wd(input int n, input int k);
    return DW'(32'hA000_0000 | (n << 16) | k);
  endfunction

  function automatic int qsize(input int n);
    case (n)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qhead(input int n);
    if (qsize(n) == 0) return '0;
    case (n)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic push(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      case (n)
        0: q0.push_back(wd(n, wseq[n]));
        1: q1.push_back(wd(n, wseq[n]));
        default: q2.push_back(wd(n, wseq[n]));
      endcase
      wseq[n]++;
    end
  endtask

  task automatic qpop(input int n);
    if (qsize(n) != 0) begin
      case (n)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
  endtask

  // Reference model: owner/remaining-words view of the arbitration rules
  bit            model_on;
  bit            m_burst;
  int            m_own, m_rem, m_last;
  logic          m_val;
  logic [1:0]    m_id;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_burst = 0; m_own = 0; m_rem = 0; m_last = 2;
    m_val = 1'b0; m_id = 2'd0; m_data = '0;
  endtask

  logic [2:0]    s_ack, s_elig;
  logic          s_val, s_busy;
  logic [1:0]    s_id;
  logic [DW-1:0] s_data;

  // One clock: present FIFO heads, sample mid-cycle, then pop what was acked.
  task automatic step();
    logic [2:0] eack;
    int w;
    int c;
    @(negedge clk);
    req = {qsize(2) != 0, qsize(1) != 0, qsize(0) != 0};
    d0 = qhead(0); d1 = qhead(1); d2 = qhead(2);
    #1;
    s_ack = ack; s_val = val; s_id = id; s_data = data; s_busy = busy;
    s_elig = req & en;
    eack = (m_burst && s_elig[m_own] && m_rem > 0) ? 3'(1 << m_own) : 3'b000;
    if (model_on) begin
      chk("model_ack", 64'(s_ack), 64'(eack));
      chk("model_busy", 64'(s_busy), 64'(m_burst));
      chk("model_val", 64'(s_val), 64'(m_val));
      chk("model_id", 64'(s_id), 64'(m_id));
      chk("model_data", 64'(s_data), 64'(m_data));
    end
    @(posedge clk);
    if (m_burst) begin
      if (eack != 3'b000) begin
        m_val = 1'b1; m_id = 2'(m_own); m_data = qhead(m_own);
        m_rem--;
        if (m_rem == 0) m_burst = 0;
      end else begin
        m_val = 1'b0; m_burst = 0;
      end
    end else begin
      m_val = 1'b0;
      if (s_elig != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (!m_burst && s_elig[c]) begin
            m_own = c; m_last = c;
            w = int'(wt[c*WW +: WW]);
            m_rem = (w == 0) ? 1 : w;
            m_burst = 1;
          end
        end
      end
    end
    for (int n = 0; n < 3; n++) if (s_ack[n]) qpop(n);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 3'b000; wt = '0; req = 3'b000;
    d0 = '0; d1 = '0; d2 = '0;
    q0.delete(); q1.delete(); q2.delete();
    for (int n = 0; n < 3; n++) wseq[n] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  typedef struct {
    logic [2:0]    ack;
    logic          val;
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          busy;
  } vec_t;

  vec_t tv[20];
  int   cnt[3];
  int   n1;
  bit   found;
  logic [2:0] seq3[6];

  initial begin
    tv[0]  = '{3'b000, 1'b0, 2'd0, '0,        1'b0};
    tv[1]  = '{3'b001, 1'b0, 2'd0, '0,        1'b1};
    tv[2]  = '{3'b001, 1'b1, 2'd0, wd(0, 0), 1'b1};
    tv[3]  = '{3'b000, 1'b1, 2'd0, wd(0, 1), 1'b0};
    tv[4]  = '{3'b010, 1'b0, 2'd0, wd(0, 1), 1'b1};
    tv[5]  = '{3'b010, 1'b1, 2'd1, wd(1, 0), 1'b1};
    tv[6]  = '{3'b000, 1'b1, 2'd1, wd(1, 1), 1'b0};
    tv[7]  = '{3'b100, 1'b0, 2'd1, wd(1, 1), 1'b1};
    tv[8]  = '{3'b100, 1'b1, 2'd2, wd(2, 0), 1'b1};
    tv[9]  = '{3'b000, 1'b1, 2'd2, wd(2, 1), 1'b0};
    tv[10] = '{3'b001, 1'b0, 2'd2, wd(2, 1), 1'b1};
    tv[11] = '{3'b001, 1'b1, 2'd0, wd(0, 2), 1'b1};
    tv[12] = '{3'b000, 1'b1, 2'd0, wd(0, 3), 1'b0};
    tv[13] = '{3'b010, 1'b0, 2'd0, wd(0, 3), 1'b1};
    tv[14] = '{3'b010, 1'b1, 2'd1, wd(1, 2), 1'b1};
    tv[15] = '{3'b000, 1'b1, 2'd1, wd(1, 3), 1'b0};
    tv[16] = '{3'b100, 1'b0, 2'd1, wd(1, 3), 1'b1};
    tv[17] = '{3'b100, 1'b1, 2'd2, wd(2, 2), 1'b1};
    tv[18] = '{3'b000, 1'b1, 2'd2, wd(2, 3), 1'b0};
    tv[19] = '{3'b000, 1'b0, 2'd2, wd(2, 3), 1'b0};

    // Equal weights 2/2/2, four words per FIFO
    model_on = 1;
    do_reset();
    chk("reset_ack", 64'(ack), 64'(0));
    chk("reset_val", 64'(val), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    en = 3'b111; wt = {4'd2, 4'd2, 4'd2};
    for (int n = 0; n < 3; n++) push(n, 4);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("tv%0d_ack", i), 64'(s_ack), 64'(tv[i].ack));
      chk($sformatf("tv%0d_val", i), 64'(s_val), 64'(tv[i].val));
      chk($sformatf("tv%0d_id", i), 64'(s_id), 64'(tv[i].id));
      chk($sformatf("tv%0d_data", i), 64'(s_data), 64'(tv[i].data));
      chk($sformatf("tv%0d_busy", i), 64'(s_busy), 64'(tv[i].busy));
    end

    // Weights 3/1/0: two full rounds of 8 cycles each
    do_reset();
    en = 3'b111; wt = {4'd0, 4'd1, 4'd3};
    for (int n = 0; n < 3; n++) push(n, 12);
    for (int n = 0; n < 3; n++) cnt[n] = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      for (int n = 0; n < 3; n++) if (s_ack[n]) cnt[n]++;
    end
    chk("wrr_ch0_words", 64'(cnt[0]), 64'(6));
    chk("wrr_ch1_words", 64'(cnt[1]), 64'(2));
    chk("wrr_ch2_words", 64'(cnt[2]), 64'(2));

    // ch0 weight 4 but only 2 words: early exit, then ch1
    do_reset();
    en = 3'b111; wt = {4'd1, 4'd2, 4'd4};
    push(0, 2); push(1, 4);
    seq3[0] = 3'b000; seq3[1] = 3'b001; seq3[2] = 3'b001;
    seq3[3] = 3'b000; seq3[4] = 3'b000; seq3[5] = 3'b010;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("short_burst_ack%0d", i), 64'(s_ack), 64'(seq3[i]));
    end

    // ch1 (weight 8) disabled after 3 words; ch2 takes over
    do_reset();
    en = 3'b111; wt = {4'd1, 4'd8, 4'd1};
    push(1, 10); push(2, 3);
    n1 = 0;
    for (int i = 0; i < 20 && en[1]; i++) begin
      step();
      if (s_ack[1]) n1++;
      if (n1 == 3) en[1] = 1'b0;
    end
    chk("en_drop_reached", 64'(en[1]), 64'(0));
    step();
    chk("en_drop_ack_stop", 64'(s_ack), 64'(0));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_ack != 3'b000) begin
        found = 1;
        chk("en_drop_next_grant", 64'(s_ack), 64'(3'b100));
      end
    end
    chk("en_drop_next_found", 64'(found), 64'(1));
    chk("en_drop_ch1_words", 64'(n1), 64'(3));

    // Reset asserted mid-burst
    do_reset();
    en = 3'b111; wt = {4'd4, 4'd4, 4'd4};
    for (int n = 0; n < 3; n++) push(n, 6);
    step(); step(); step();
    rstn = 1'b0;
    #1;
    chk("mid_rst_ack", 64'(ack), 64'(0));
    chk("mid_rst_val", 64'(val), 64'(0));
    chk("mid_rst_id", 64'(id), 64'(0));
    chk("mid_rst_data", 64'(data), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (s_ack != 3'b000) begin
        found = 1;
        chk("mid_rst_first_grant", 64'(s_ack), 64'(3'b001));
      end
    end
    chk("mid_rst_grant_found", 64'(found), 64'(1));

    // Randomized traffic, enables and weights against the model
    do_reset();
    en = 3'b111; wt = 12'($urandom);
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 3; n++)
        if (qsize(n) < 6 && ($urandom % 3) == 0) push(n, 1);
      if (($urandom % 32) == 0) en = en ^ 3'(1 << ($urandom % 3));
      if (($urandom % 64) == 0) wt = 12'($urandom);
      step();
    end

`ifdef MCDT_ARB_WORD_CNT_EN
    // Only ch2 enabled, 17 words: 4-bit counter wraps to 1
    do_reset();
    en = 3'b100; wt = {4'd3, 4'd3, 4'd3};
    push(2, 17);
    for (int i = 0; i < 80 && qsize(2) != 0; i++) step();
    chk("cnt_drained", 64'(qsize(2)), 64'(0));
    step(); step();
    chk("cnt_ch0", 64'(wcnt[0*CW +: CW]), 64'(0));
    chk("cnt_ch1", 64'(wcnt[1*CW +: CW]), 64'(0));
    chk("cnt_ch2", 64'(wcnt[2*CW +: CW]), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
